// File: rtl/paddle_sprite.sv
// paddle_sprite: two-stage pixel renderer for the Curveball paddle.
// Positions are double-buffered so they change only at frame_start, and a
// small FSM alternates the fill colour for a number of frames after a hit.
module paddle_sprite #(
    parameter int unsigned PAD_W        = 24,
    parameter int unsigned PAD_H        = 18,
    parameter int unsigned CORNER       = 3,
    parameter int unsigned BORDER       = 1,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_x_loc,
    input  logic [15:0] i_y_loc,
    input  logic        i_loc_valid,
    input  logic        i_frame_start,
    input  logic        i_hit,
    input  logic [15:0] i_pixel_x,
    input  logic [15:0] i_pixel_y,
    input  logic        i_pixel_valid,
    output logic [23:0] o_color,
    output logic        o_color_valid,
    output logic        o_in_paddle
);

    localparam logic [15:0] PW     = 16'(PAD_W);
    localparam logic [15:0] PH     = 16'(PAD_H);
    localparam logic [15:0] HALF_W = 16'(PAD_W / 2);
    localparam logic [15:0] HALF_H = 16'(PAD_H / 2);
    localparam logic [16:0] CORN   = 17'(CORNER);
    localparam logic [15:0] BRD    = 16'(BORDER);
    localparam logic [7:0]  FLASH_CNT = 8'(FLASH_FRAMES);

    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GRAY  = 24'hD3D3D3;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLASH = 1'b1;

    // Position shadow registers
    logic [15:0] r_x_pend, r_y_pend, r_x_act, r_y_act;

    // Flash FSM
    logic [0:0] r_state, w_state_d;
    logic [7:0] r_cnt, w_cnt_d;
    logic       r_phase, w_phase_d;

    // Stage 1 pipeline
    logic        r_s1_inside, r_s1_cx, r_s1_cy, r_s1_valid, r_s1_phase;
    logic [15:0] r_s1_fx, r_s1_fy;

    // Stage 2 outputs
    logic [23:0] r_color;
    logic        r_color_valid, r_in_paddle;

    logic [15:0] w_dx, w_dy, w_fx, w_fy;
    logic        w_inside;
    logic [16:0] w_sum;
    logic [23:0] w_color;
    logic        w_in_paddle;

    // Pending/active position: a same-cycle load bypasses pending into active
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x_pend <= '0;
            r_y_pend <= '0;
            r_x_act  <= '0;
            r_y_act  <= '0;
        end else begin
            if (i_loc_valid) begin
                r_x_pend <= i_x_loc;
                r_y_pend <= i_y_loc;
            end
            if (i_frame_start) begin
                r_x_act <= i_loc_valid ? i_x_loc : r_x_pend;
                r_y_act <= i_loc_valid ? i_y_loc : r_y_pend;
            end
        end
    end

    // Flash next-state: hit always wins over a coincident frame_start
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_phase_d = r_phase;
        if (i_hit) begin
            w_state_d = ST_FLASH;
            w_cnt_d   = FLASH_CNT;
            w_phase_d = 1'b1;
        end else if (r_state == ST_FLASH && i_frame_start) begin
            if (r_cnt == 8'd1) begin
                w_state_d = ST_IDLE;
                w_cnt_d   = 8'd0;
                w_phase_d = 1'b0;
            end else begin
                w_cnt_d   = r_cnt - 8'd1;
                w_phase_d = ~r_phase;
            end
        end
    end

    // Flash state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_phase <= w_phase_d;
        end
    end

    // The >= compares reject pixels left/above the paddle that wrap into range
    assign w_dx     = i_pixel_x - r_x_act;
    assign w_dy     = i_pixel_y - r_y_act;
    assign w_inside = (i_pixel_x >= r_x_act) && (w_dx < PW) &&
                      (i_pixel_y >= r_y_act) && (w_dy < PH);
    assign w_fx     = (w_dx < HALF_W) ? w_dx : (PW - 16'd1 - w_dx);
    assign w_fy     = (w_dy < HALF_H) ? w_dy : (PH - 16'd1 - w_dy);

    // Stage 1: phase travels with the pixel so it matches presentation time
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_inside <= 1'b0;
            r_s1_fx     <= '0;
            r_s1_fy     <= '0;
            r_s1_cx     <= 1'b0;
            r_s1_cy     <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_phase  <= 1'b0;
        end else begin
            r_s1_inside <= w_inside;
            r_s1_fx     <= w_fx;
            r_s1_fy     <= w_fy;
            r_s1_cx     <= (w_dx == HALF_W);
            r_s1_cy     <= (w_dy == HALF_H);
            r_s1_valid  <= i_pixel_valid;
            r_s1_phase  <= r_phase;
        end
    end

    assign w_sum = {1'b0, r_s1_fx} + {1'b0, r_s1_fy};

    // Stage 2 classification, first match wins
    always_comb begin
        w_color     = BLACK;
        w_in_paddle = 1'b0;
        if (!r_s1_inside || w_sum < CORN) begin
            w_color     = BLACK;
            w_in_paddle = 1'b0;
        end else if (w_sum == CORN || r_s1_fx < BRD || r_s1_fy < BRD) begin
            w_color     = RED;
            w_in_paddle = 1'b1;
        end else if (r_s1_cx || r_s1_cy) begin
            w_color     = RED;
            w_in_paddle = 1'b1;
        end else begin
            w_color     = r_s1_phase ? WHITE : GRAY;
            w_in_paddle = 1'b1;
        end
    end

    // Stage 2 output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_color       <= BLACK;
            r_color_valid <= 1'b0;
            r_in_paddle   <= 1'b0;
        end else begin
            r_color       <= w_color;
            r_color_valid <= r_s1_valid;
            r_in_paddle   <= w_in_paddle;
        end
    end

    assign o_color       = r_color;
    assign o_color_valid = r_color_valid;
    assign o_in_paddle   = r_in_paddle;

endmodule
